// File: rtl/data_sram_bridge.sv
// Purpose : turns the M-stage single-cycle data RAM access into a split
//           request / address-ack / data-ack bus transfer.
// Latency : at least 3 stall cycles per access (IDLE, ADDR, DATA), then
//           one DONE cycle in which the pipeline is released.
// Backpr. : the pipeline is held through cpu_stall until data_ok. Bus wait
//           states on addr_ok or data_ok each add one stall cycle.
//
// Ports
//   clk, rst           pipeline clock, asynchronous active-low reset
//   cpu_en/wen/addr/wdata  M-stage request (wen == 0 means read)
//   cpu_rdata          last captured read word (aligned 32-bit, raw)
//   cpu_stall          combinational hold for the F/D/E/M stages
//   req/wr/size/addr/wdata/wstrb  registered bus request fields
//   addr_ok, data_ok, rdata       bus handshake and read data
module data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic              req_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] rdata_q;

  // Bus transfer size from the byte strobes. Reads always fetch a full
  // aligned word; illegal strobe patterns are sent as word accesses with
  // the strobes passed through untouched.
  function automatic logic [1:0] size_of(input logic [3:0] strb);
    logic [1:0] s;
    case (strb)
      4'b0000, 4'b1111:                   s = 2'd2;
      4'b1100, 4'b0011:                   s = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: s = 2'd0;
      default:                            s = 2'd2;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // CPU inputs are sampled only here; later changes (e.g. a flush)
          // cannot disturb a transfer already in flight.
          if (cpu_en) begin
            req_q   <= 1'b1;
            wr_q    <= |cpu_wen;
            size_q  <= size_of(cpu_wen);
            wstrb_q <= cpu_wen;
            wdata_q <= cpu_wdata;
            addr_q  <= (|cpu_wen) ? cpu_addr : {cpu_addr[ADDR_W-1:2], 2'b00};
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (addr_ok) begin
            req_q   <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (data_ok) begin
            if (!wr_q) rdata_q <= rdata;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the stall is already up in the IDLE cycle where
  // cpu_en first rises; released only for the single DONE cycle.
  assign cpu_stall = cpu_en & (state_q != DONE);

  assign req       = req_q;
  assign wr        = wr_q;
  assign size      = size_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: inputs are driven 1 time unit after
// the rising edge, outputs are sampled on the falling edge of the same cycle.
module tb_data_sram_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start of a new cycle: just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One zero-wait transfer occupying exactly four cycles (IDLE..DONE).
  // Leaves cpu_en high so a following call is a back-to-back access.
  task automatic xfer(input string tag, input logic [3:0] wen, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd_bus,
                      input logic [31:0] exp_addr, input logic [1:0] exp_size,
                      input logic [31:0] exp_rd);
    tick();
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd;
    sample();
    chk({tag, ".c0.stall"}, 32'(cpu_stall), 32'd1);
    chk({tag, ".c0.req"},   32'(req),       32'd0);
    tick();
    addr_ok = 1'b1;
    sample();
    chk({tag, ".c1.req"},   32'(req),   32'd1);
    chk({tag, ".c1.addr"},  addr,       exp_addr);
    chk({tag, ".c1.size"},  32'(size),  32'(exp_size));
    chk({tag, ".c1.wr"},    32'(wr),    32'(|wen));
    chk({tag, ".c1.wstrb"}, 32'(wstrb), 32'(wen));
    chk({tag, ".c1.wdata"}, wdata,      wd);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = rd_bus;
    sample();
    chk({tag, ".c2.req"},   32'(req),       32'd0);
    chk({tag, ".c2.stall"}, 32'(cpu_stall), 32'd1);
    tick();
    data_ok = 1'b0; rdata = 32'h0;
    sample();
    chk({tag, ".c3.stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, ".c3.rdata"}, cpu_rdata,      exp_rd);
  endtask

  task automatic go_idle(input string tag);
    tick();
    cpu_en = 1'b0; cpu_wen = 4'b0000;
    sample();
    chk({tag, ".idle.stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, ".idle.req"},   32'(req),       32'd0);
  endtask

  initial begin
    rst = 1'b0; cpu_en = 1'b0; cpu_wen = 4'b0000; cpu_addr = 32'h0;
    cpu_wdata = 32'h0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;

    // ---- reset state
    tick(); tick();
    sample();
    chk("rst.req",   32'(req),       32'd0);
    chk("rst.wr",    32'(wr),        32'd0);
    chk("rst.size",  32'(size),      32'd0);
    chk("rst.addr",  addr,           32'h0);
    chk("rst.wdata", wdata,          32'h0);
    chk("rst.wstrb", 32'(wstrb),     32'd0);
    chk("rst.rdata", cpu_rdata,      32'h0);
    chk("rst.stall0", 32'(cpu_stall), 32'd0);
    cpu_en = 1'b1;
    #1;
    chk("rst.stall1", 32'(cpu_stall), 32'd1);
    cpu_en = 1'b0;
    rst = 1'b1;

    // ---- word read, unaligned address gets aligned
    xfer("rd", 4'b0000, 32'h1000_0006, 32'h0, 32'hDEAD_BEEF,
         32'h1000_0004, 2'd2, 32'hDEAD_BEEF);
    go_idle("rd");

    // ---- byte store, addr_ok held off for 3 cycles, data_ok one late
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h0000_2001; cpu_wdata = 32'h5A5A_5A5A;
    sample();
    chk("bs.c0.stall", 32'(cpu_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      // Upstream changes mid-transfer must not leak onto the bus.
      cpu_addr = 32'hFFFF_FFF0; cpu_wdata = 32'h1234_5678;
      addr_ok = (i == 3);
      sample();
      chk("bs.req",   32'(req),       32'd1);
      chk("bs.addr",  addr,           32'h0000_2001);
      chk("bs.wdata", wdata,          32'h5A5A_5A5A);
      chk("bs.wstrb", 32'(wstrb),     32'h4);
      chk("bs.size",  32'(size),      32'd0);
      chk("bs.wr",    32'(wr),        32'd1);
      chk("bs.stall", 32'(cpu_stall), 32'd1);
    end
    tick();
    addr_ok = 1'b0;
    sample();
    chk("bs.wait.req",   32'(req),       32'd0);
    chk("bs.wait.stall", 32'(cpu_stall), 32'd1);
    tick();
    data_ok = 1'b1; rdata = 32'h1111_1111;
    sample();
    chk("bs.dok.stall", 32'(cpu_stall), 32'd1);
    tick();
    data_ok = 1'b0;
    sample();
    chk("bs.done.stall", 32'(cpu_stall), 32'd0);
    chk("bs.done.rdata", cpu_rdata,      32'hDEAD_BEEF);
    tick();
    sample();
    chk("bs.after.stall", 32'(cpu_stall), 32'd1);
    cpu_en = 1'b0;
    go_idle("bs");

    // ---- size decode
    xfer("sz1100", 4'b1100, 32'h0000_3002, 32'hAABB_AABB, 32'h0, 32'h0000_3002, 2'd1, 32'hDEAD_BEEF);
    go_idle("sz1100");
    xfer("sz1111", 4'b1111, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 32'h0000_3004, 2'd2, 32'hDEAD_BEEF);
    go_idle("sz1111");
    xfer("sz0101", 4'b0101, 32'h0000_3008, 32'h0102_0304, 32'h0, 32'h0000_3008, 2'd2, 32'hDEAD_BEEF);
    go_idle("sz0101");

    // ---- back-to-back load then store: second req in cycle 5
    xfer("b2b.ld", 4'b0000, 32'h0000_4003, 32'h0, 32'h0BAD_CAFE, 32'h0000_4000, 2'd2, 32'h0BAD_CAFE);
    xfer("b2b.st", 4'b0011, 32'h0000_4010, 32'h7777_7777, 32'h5555_5555, 32'h0000_4010, 2'd1, 32'h0BAD_CAFE);
    go_idle("b2b");

    // ---- spurious data_ok while in ADDR
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_5000;
    sample();
    chk("sp.c0.stall", 32'(cpu_stall), 32'd1);
    tick();
    data_ok = 1'b1; rdata = 32'hBAD0_BAD0;
    sample();
    chk("sp.addr.req", 32'(req), 32'd1);
    tick();
    data_ok = 1'b0; rdata = 32'h0;
    sample();
    chk("sp.still.req",   32'(req),       32'd1);
    chk("sp.still.stall", 32'(cpu_stall), 32'd1);
    chk("sp.still.rdata", cpu_rdata,      32'h0BAD_CAFE);
    tick();
    addr_ok = 1'b1;
    sample();
    chk("sp.aok.req", 32'(req), 32'd1);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h600D_F00D;
    sample();
    chk("sp.data.req",   32'(req),       32'd0);
    chk("sp.data.stall", 32'(cpu_stall), 32'd1);
    tick();
    data_ok = 1'b0;
    sample();
    chk("sp.done.stall", 32'(cpu_stall), 32'd0);
    chk("sp.done.rdata", cpu_rdata,      32'h600D_F00D);
    go_idle("sp");

    // ---- reset while in DATA
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_6008;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    sample();
    chk("rd.data.addr", addr, 32'h0000_6008);
    rst = 1'b0;
    #1;
    chk("rstm.req",   32'(req),  32'd0);
    chk("rstm.addr",  addr,      32'h0);
    chk("rstm.rdata", cpu_rdata, 32'h0);
    chk("rstm.wstrb", 32'(wstrb), 32'd0);
    tick();
    rst = 1'b1;
    sample();
    chk("rstm.idle.req",   32'(req),       32'd0);
    chk("rstm.idle.stall", 32'(cpu_stall), 32'd1);
    tick();
    addr_ok = 1'b1;
    sample();
    chk("rstm.addr.req",  32'(req), 32'd1);
    chk("rstm.addr.addr", addr,     32'h0000_6008);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0F0F_0F0F;
    sample();
    chk("rstm.data.stall", 32'(cpu_stall), 32'd1);
    tick();
    data_ok = 1'b0;
    sample();
    chk("rstm.done.stall", 32'(cpu_stall), 32'd0);
    chk("rstm.done.rdata", cpu_rdata,      32'h0F0F_0F0F);
    go_idle("rstm");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Memory-stage data-access bridge sitting directly downstream of the pipeline datapath's M-stage data RAM port (address, byte strobes, write data, read data). Converts the datapath's single-cycle request into a split-transaction request/address-ack/data-ack bus transfer. Holds the pipeline with a stall until the transfer completes. Returns the raw aligned 32-bit read word; byte/halfword extraction stays in the datapath.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset: 0 resets, 1 runs
- cpu_en  in  1  M-stage instruction is a load/store
- cpu_wen  in  4  byte write strobes from the datapath `sel`; 4'b0000 means read
- cpu_addr  in  ADDR_W  byte address, the M-stage ALU result
- cpu_wdata  in  DATA_W  byte-replicated store data
- cpu_rdata  out  DATA_W  captured read word
- cpu_stall  out  1  hold F/D/E/M stages
- req  out  1  bus request
- wr  out  1  1 = write, 0 = read
- size  out  2  0 = byte, 1 = half, 2 = word
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- wstrb  out  4  bus byte strobes, latched `cpu_wen`
- addr_ok  in  1  request accepted this cycle
- data_ok  in  1  read data valid / write done this cycle
- rdata  in  DATA_W  bus read data

## Operation
- FSM states are IDLE, ADDR, DATA and DONE. Reset state is IDLE.
- **IDLE**
  - When cpu_en=1, latch wr=|cpu_wen, wstrb, wdata and size, then go to ADDR.
  - Address latch: writes latch cpu_addr unchanged. Reads latch {cpu_addr[ADDR_W-1:2],2'b00}.
- **size derivation**
  - Read: 2.
  - Strobe 1111: 2.
  - Strobe 1100 or 0011: 1.
  - One-hot strobe: 0.
  - Any other nonzero pattern: 2 (illegal, passed through as-is).
- **ADDR**
  - req=1.
  - addr, wr, size, wdata and wstrb stay stable until addr_ok.
  - On addr_ok=1: req drops next cycle, go to DATA.
- **DATA**
  - req=0.
  - On data_ok=1: if wr=0, cpu_rdata<=rdata. Go to DONE.
  - data_ok is ignored in any state other than DATA. The bus guarantees data_ok comes at least 1 cycle after addr_ok.
- **DONE**
  - Pipeline releases for exactly one cycle, then unconditionally returns to IDLE.
- **cpu_stall** (combinational)
  - cpu_stall = cpu_en & (state != DONE).
  - It is 1 in the IDLE cycle where cpu_en first rises, so the datapath never advances before completion.
- **cpu_rdata**
  - Registered. Holds its last captured value until the next read's data_ok.
  - Writes never modify it.
- **Mid-transfer input changes**: cpu_en, cpu_addr and cpu_wdata may change during ADDR/DATA (e.g. a flush). The latched transfer still completes. Inputs are sampled only in IDLE.
- **Reset mid-operation**
  - FSM returns to IDLE immediately (asynchronous).
  - req, wr, size, addr, wdata, wstrb and cpu_rdata go to 0.
  - Any outstanding bus transfer is abandoned. Discarding its late data_ok is the bus's responsibility.

## Timing
- Reset values: req=0, wr=0, size=0, addr=0, wdata=0, wstrb=0, cpu_rdata=0, FSM=IDLE. cpu_stall follows cpu_en (state is not DONE).
- Minimum access, with addr_ok in the first ADDR cycle and data_ok on the next cycle:
  - Cycle 0: IDLE, cpu_en=1, stall=1.
  - Cycle 1: ADDR, req=1, addr_ok=1.
  - Cycle 2: DATA, data_ok=1.
  - Cycle 3: DONE, stall=0, cpu_rdata valid.
  - Result: 3 stall cycles, load data usable by the datapath in cycle 3.
- Each bus cycle without addr_ok, or without data_ok, adds exactly one stall cycle.
- Back-to-back accesses:
  - DONE is followed by IDLE. A new cpu_en seen in that IDLE cycle starts the next transfer.
  - Minimum spacing is 4 cycles per access.
- All outputs except cpu_stall are registered.

## Test plan
- **Word read**: cpu_en=1, wen=0, addr=0x1000_0006, addr_ok in cycle 1, data_ok in cycle 2 with rdata=0xDEAD_BEEF.
  - Required: addr=0x1000_0004, size=2, wr=0, wstrb=0.
  - Required: stall high in cycles 0-2, low in cycle 3, cpu_rdata=0xDEAD_BEEF.
- **Byte store**: wen=4'b0100, addr=0x2001, wdata=0x5A5A_5A5A, addr_ok delayed 3 cycles.
  - Required: req high for 4 cycles with addr/wdata/wstrb stable, size=0, wr=1.
  - Required: cpu_rdata unchanged, stall releases exactly 1 cycle after data_ok.
- **Size decode**:
  - wen=1100 gives size=1.
  - wen=1111 gives size=2.
  - wen=0101 gives size=2 and wr=1.
- **Back-to-back**: load then store with zero-wait bus.
  - Required: second req rises in cycle 5.
  - Required: cpu_rdata keeps the load data through the store.
- **Spurious data_ok**: data_ok=1 while in ADDR.
  - Required: ignored, no capture, FSM stays in ADDR until addr_ok.
- **Reset in DATA**: drive rst=0 mid-cycle.
  - Required: req, addr and cpu_rdata go to 0 immediately, FSM is IDLE.
  - Required: after rst=1, a fresh access completes normally.
